// File: rtl/debouncer_multi.sv
// debouncer_multi: multi-channel input conditioner for buttons, DIP switches
// and board status pins. Each channel synchronises its raw pin, requires the
// new level to hold for STABLE_CNT sample ticks, then updates its level. Each
// change produces a one-clk rise/fall pulse and sets a sticky event flag.
// A single prescaler is shared by all channels and produces the sample tick.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   d_in       in   NUM_CH  raw asynchronous inputs
//   d_out      out  NUM_CH  debounced levels
//   rise_pulse out  NUM_CH  1-clk pulse, d_out[i] inactive->active
//   fall_pulse out  NUM_CH  1-clk pulse, d_out[i] active->inactive
//   evt_flag   out  NUM_CH  sticky change flag per channel
//   evt_clr    in   NUM_CH  clears evt_flag[i]; a same-cycle set wins

// One channel: synchroniser, stability counter, level, pulses and flag.
module debouncer_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 1000,
  parameter int ACTIVE_VAL  = 1,
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic d_in,
  input  logic evt_clr,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic evt_flag
);
  localparam logic ACT  = (ACTIVE_VAL != 0);
  localparam logic IDLE = ~ACT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  // Any tick where the synchronised level matches the accepted one restarts
  // the qualification; the counter therefore never passes CNT_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      d_out      <= IDLE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (tick) begin
        if (s == d_out) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt        <= '0;
          d_out      <= s;
          rise_pulse <= (s == ACT);
          fall_pulse <= (s != ACT);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Flag is set from the registered pulses, so a clear issued while the pulse
  // is visible loses to the set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_flag <= 1'b0;
    end else begin
      evt_flag <= rise_pulse | fall_pulse | (evt_flag & ~evt_clr);
    end
  end
endmodule

module debouncer_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 1000,
  parameter int TICK_DIV    = 1,
  parameter int ACTIVE_VAL  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] d_in,
  output logic [NUM_CH-1:0] d_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] evt_flag,
  input  logic [NUM_CH-1:0] evt_clr
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  // Keep the prescaler at least one bit wide; with TICK_DIV=1 it sits at 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debouncer_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT),
      .ACTIVE_VAL  (ACTIVE_VAL),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .d_in       (d_in[g]),
      .evt_clr    (evt_clr[g]),
      .d_out      (d_out[g]),
      .rise_pulse (rise_pulse[g]),
      .fall_pulse (fall_pulse[g]),
      .evt_flag   (evt_flag[g])
    );
  end
endmodule

// File: tb/tb_debouncer_multi.sv
module tb_debouncer_multi;
  localparam int N  = 4;
  localparam int SY = 2;
  localparam int SC = 8;

  logic clk, rst_n;
  logic [N-1:0] d_in, evt_clr, d_out, rise, fall, flag;
  logic [N-1:0] t4_din, t4_clr, t4_dout, t4_rise, t4_fall, t4_flag;
  logic [N-1:0] al_din, al_clr, al_dout, al_rise, al_fall, al_flag;

  int checks, errors;

  debouncer_multi #(.NUM_CH(N), .SYNC_STAGES(SY), .STABLE_CNT(SC), .TICK_DIV(1), .ACTIVE_VAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_out(d_out), .rise_pulse(rise),
    .fall_pulse(fall), .evt_flag(flag), .evt_clr(evt_clr));

  debouncer_multi #(.NUM_CH(N), .SYNC_STAGES(SY), .STABLE_CNT(SC), .TICK_DIV(4), .ACTIVE_VAL(1)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .d_in(t4_din), .d_out(t4_dout), .rise_pulse(t4_rise),
    .fall_pulse(t4_fall), .evt_flag(t4_flag), .evt_clr(t4_clr));

  debouncer_multi #(.NUM_CH(N), .SYNC_STAGES(SY), .STABLE_CNT(SC), .TICK_DIV(1), .ACTIVE_VAL(0)) dut_al (
    .clk(clk), .rst_n(rst_n), .d_in(al_din), .d_out(al_dout), .rise_pulse(al_rise),
    .fall_pulse(al_fall), .evt_flag(al_flag), .evt_clr(al_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the synchronised level is the input seen SY edges ago
  // (queue of past samples); a level is accepted after SC consecutive edges
  // of disagreement with the current output.
  logic [N-1:0] m_out, m_rise, m_fall, m_flag;
  int           streak [N];
  logic [N-1:0] m_hist [$];

  task automatic model_reset();
    m_out = '0; m_rise = '0; m_fall = '0; m_flag = '0;
    for (int c = 0; c < N; c++) streak[c] = 0;
    m_hist = {};
    for (int i = 0; i < SY; i++) m_hist.push_back('0);
  endtask

  task automatic model_step();
    logic [N-1:0] s_prev, nr, nf;
    s_prev = m_hist.pop_front();
    m_hist.push_back(d_in);
    m_flag = m_rise | m_fall | (m_flag & ~evt_clr);
    nr = '0; nf = '0;
    for (int c = 0; c < N; c++) begin
      if (s_prev[c] != m_out[c]) begin
        streak[c]++;
        if (streak[c] == SC) begin
          m_out[c] = s_prev[c];
          if (s_prev[c]) nr[c] = 1'b1; else nf[c] = 1'b1;
          streak[c] = 0;
        end
      end else begin
        streak[c] = 0;
      end
    end
    m_rise = nr; m_fall = nf;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("model_d_out", 32'(d_out), 32'(m_out));
    chk("model_rise", 32'(rise), 32'(m_rise));
    chk("model_fall", 32'(fall), 32'(m_fall));
    chk("model_flag", 32'(flag), 32'(m_flag));
  endtask

  int t4_first;
  int rate;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    d_in = '0; evt_clr = '0;
    t4_din = '0; t4_clr = '0;
    al_din = '1; al_clr = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_out", 32'(d_out), 32'h0);
    chk("rst_pulses", 32'(rise | fall), 32'h0);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_al_d_out", 32'(al_dout), 32'hF);
    chk("rst_t4_d_out", 32'(t4_dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // TICK_DIV=4 latency with a known prescaler phase, and ACTIVE_VAL=0
    cyc(); cyc();
    t4_din[0] = 1'b1;
    al_din[1] = 1'b0;
    t4_first = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (k == 9) chk("al_before", 32'(al_dout), 32'hF);
      if (k == 10) begin
        chk("al_d_out", 32'(al_dout), 32'hD);
        chk("al_rise", 32'(al_rise), 32'h2);
        chk("al_fall", 32'(al_fall), 32'h0);
      end
      if (t4_first == 0 && t4_dout[0]) begin
        t4_first = k;
        chk("t4_rise", 32'(t4_rise), 32'h1);
      end
    end
    chk("t4_latency", 32'(t4_first), 32'd34);

    // 1: single channel rise
    d_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 9) chk("t1_before", 32'(d_out), 32'h0);
      if (k == 10) begin
        chk("t1_d_out", 32'(d_out), 32'h1);
        chk("t1_rise", 32'(rise), 32'h1);
      end
    end
    cyc();
    chk("t1_flag", 32'(flag), 32'h1);
    chk("t1_rise_one", 32'(rise), 32'h0);

    // 2: bounce shorter than the filter is rejected
    d_in[1] = 1'b1;
    repeat (7) cyc();
    d_in[1] = 1'b0;
    cyc();
    d_in[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 9) chk("t2_before", 32'(d_out[1]), 32'h0);
      if (k == 10) begin
        chk("t2_d_out", 32'(d_out[1]), 32'h1);
        chk("t2_rise", 32'(rise), 32'h2);
      end
    end

    // 3: simultaneous rise and fall on different channels
    d_in[3] = 1'b1;
    repeat (12) cyc();
    evt_clr = '1;
    cyc();
    evt_clr = '0;
    chk("t3_cleared", 32'(flag), 32'h0);
    d_in[2] = 1'b1;
    d_in[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 10) begin
        chk("t3_rise", 32'(rise), 32'h4);
        chk("t3_fall", 32'(fall), 32'h8);
      end
    end

    // 6: set wins over clear in the same cycle; later clear works
    d_in[0] = 1'b0;
    repeat (12) cyc();
    evt_clr = '1;
    cyc();
    evt_clr = '0;
    d_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 10) chk("t6_rise", 32'(rise[0]), 32'h1);
    end
    evt_clr[0] = 1'b1;
    cyc();
    chk("t6_set_wins", 32'(flag[0]), 32'h1);
    evt_clr[0] = 1'b0;
    cyc();
    evt_clr[0] = 1'b1;
    cyc();
    chk("t6_clear", 32'(flag[0]), 32'h0);
    evt_clr[0] = 1'b0;

    // 4: reset mid-count discards the partial count
    d_in[0] = 1'b0;
    repeat (12) cyc();
    d_in[0] = 1'b1;
    repeat (7) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t4r_d_out", 32'(d_out), 32'h0);
    chk("t4r_flag", 32'(flag), 32'h0);
    chk("t4r_pulses", 32'(rise | fall), 32'h0);
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 9) chk("t4r_before", 32'(d_out), 32'h0);
      if (k == 10) begin
        chk("t4r_d_out_after", 32'(d_out), 32'h7);
        chk("t4r_rise", 32'(rise), 32'h7);
      end
    end

    // Random bouncy/quiet phases against the model
    for (int i = 0; i < 600; i++) begin
      rate = ((i / 100) % 2 == 1) ? 3 : 35;
      for (int c = 0; c < N; c++)
        if ($urandom_range(99) < rate) d_in[c] = ~d_in[c];
      evt_clr = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      if (i == 350) begin
        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
